ppu_mem_ctrl: RTL and testbench
===============================

PPU_MEM_CTRL -- requirements
Module: ppu_mem_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning pending-write queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cpu_addr  input  3  CPU register select ($2000+n).
REQ-005 SHALL have port cpu_data_in  input  8  CPU write data.
REQ-006 SHALL have port cpu_wr_en  input  1  one-cycle CPU register write strobe.
REQ-007 SHALL have port cpu_rd_en  input  1  one-cycle CPU register read strobe.
REQ-008 SHALL have port inc32  input  1  PPUCTRL bit 2; 1 means increment 32, 0 means increment 1.
REQ-009 SHALL have port mem_write_allow  input  1  high when PPU memory may be written (vblank or rendering off).
REQ-010 SHALL have port write_addr  output  16  PPU memory write address, registered.
REQ-011 SHALL have port write_data  output  8  PPU memory write data, registered.
REQ-012 SHALL have port write_en  output  1  one-cycle write strobe, registered.
REQ-013 SHALL have port fifo_full  output  1  queue holds FIFO_DEPTH entries.
REQ-014 SHALL have port overflow  output  1  sticky; a $2007 write was dropped.

Function
REQ-015 SHALL hold a 14-bit VRAM address v, a 14-bit temp t, and a 1-bit write toggle w.
REQ-016 Write to reg 6 with w=0 SHALL set t[13:8]=cpu_data_in[5:0] and w=1; bits 7:6 are ignored.
REQ-017 Write to reg 6 with w=1 SHALL set t[7:0]=cpu_data_in, v=new t (same edge), and w=0.
REQ-018 Read of reg 2 SHALL clear w; reads of all other registers SHALL have no effect.
REQ-019 If cpu_wr_en and cpu_rd_en are both high, the write SHALL be performed and the read ignored.
REQ-020 Write to reg 7 SHALL push {v, cpu_data_in} into the queue, then set v=(v+(inc32?32:1)) mod 2^14.
REQ-021 v SHALL wrap 0x3FFF->0x0000 (inc 1) and 0x3FE0+k->k (inc 32) with no carry beyond bit 13.
REQ-022 Writes to regs 0,1,3,4,5 SHALL be ignored.
REQ-023 Queue SHALL be FIFO ordered; drain SHALL pop one entry per cycle while non-empty and mem_write_allow=1.
REQ-024 Pop SHALL produce write_en=1 on the next cycle, with write_addr={2'b00, entry addr} and write_data=entry data; write_en otherwise 0.
REQ-025 Latency: reg 7 write at edge N into an empty queue with allow=1 SHALL give write_en high during cycle N+1 to N+2 (one pop edge, one output edge).
REQ-026 Push while full and no pop SHALL drop data, set overflow=1, and still increment v.
REQ-027 Simultaneous push and pop SHALL be legal at any occupancy including full; occupancy unchanged.
REQ-028 fifo_full SHALL reflect occupancy==FIFO_DEPTH after the current edge; it is registered.
REQ-029 mem_write_allow falling SHALL stop pops from the next edge; an entry already popped SHALL still issue write_en.
REQ-030 write_addr/write_data SHALL hold last values when write_en=0.

Reset
REQ-031 rst low SHALL asynchronously clear v, t, w, queue pointers/occupancy, overflow, fifo_full, write_en, write_addr, write_data to 0.
REQ-032 Reset mid-drain SHALL discard all queued entries; no write_en after reset release until a new reg 7 write.
REQ-033 overflow SHALL clear only on reset.

Structure
REQ-034 Register indices (PPUCTRL=0, PPUSTATUS=2, PPUADDR=6, PPUDATA=7), VRAM_ADDR_MASK=14'h3FFF, and increment constants SHALL live in a shared ppu package.
REQ-035 The queue SHALL be a sub-module named ppu_wr_fifo (parameterised depth, push/pop/full/empty); remaining logic is in ppu_mem_ctrl.

Verification
REQ-036 Reg 6 writes 0x23 then 0x05, reg 7 write 0xAB, allow=1 -> single write_en with write_addr=0x2305, write_data=0xAB; v=0x2306.
REQ-037 inc32=1, v=0x3FE1, reg 7 write 0x11 -> write at 0x3FE1, v becomes 0x0001.
REQ-038 Reg 6 write 0x3F, reg 2 read, reg 6 write 0x21 -> w=1 and t[13:8]=0x21, v unchanged.
REQ-039 allow=0, five reg 7 writes with data 1..5 (depth 4) -> fifo_full=1, overflow=1; set allow=1 -> four writes with data 1..4 in order at consecutive addresses, fifth address skipped.
REQ-040 Two entries queued, allow=1; assert rst low during first write_en -> all outputs 0 at once, no further write_en after release.
REQ-041 Queue full, allow=1, reg 7 write on a pop edge -> no overflow, occupancy stays 4, new entry drains last.

Source files
------------

// File: rtl/ppu_mem_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// ppu_mem_ctrl_pkg : register map, VRAM address constants, queue entry
// Rev 1.0
// ----------------------------------------------------------------
package ppu_mem_ctrl_pkg;

  localparam logic [2:0]  REG_PPUCTRL    = 3'd0;
  localparam logic [2:0]  REG_PPUSTATUS  = 3'd2;
  localparam logic [2:0]  REG_PPUADDR    = 3'd6;
  localparam logic [2:0]  REG_PPUDATA    = 3'd7;

  localparam logic [13:0] VRAM_ADDR_MASK = 14'h3FFF;
  localparam logic [13:0] VRAM_INC_1     = 14'd1;
  localparam logic [13:0] VRAM_INC_32    = 14'd32;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  // The 14-bit sum already wraps; the mask keeps the intent explicit.
  function automatic logic [13:0] vram_next(input logic [13:0] v, input logic inc32);
    return (v + (inc32 ? VRAM_INC_32 : VRAM_INC_1)) & VRAM_ADDR_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_wr_fifo.sv
`default_nettype none
// ----------------------------------------------------------------
// ppu_wr_fifo : pending PPU write queue; a push on a pop cycle is accepted even when full
// Rev 1.0
// ----------------------------------------------------------------
module ppu_wr_fifo
  import ppu_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  wr_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppu_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// ppu_mem_ctrl : $2006 address latch, $2007 write queue and memory write port
// Rev 1.0
// ----------------------------------------------------------------
module ppu_mem_ctrl
  import ppu_mem_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wr_en,
  input  logic        cpu_rd_en,
  input  logic        inc32,
  input  logic        mem_write_allow,
  output logic [15:0] write_addr,
  output logic [7:0]  write_data,
  output logic        write_en,
  output logic        fifo_full,
  output logic        overflow
);

  logic [13:0] v_q, v_d, t_q, t_d;
  logic        w_q, w_d;
  logic        push, pop, q_full, q_empty;
  logic        overflow_q, overflow_d;
  logic [15:0] write_addr_q;
  logic [7:0]  write_data_q;
  logic        write_en_q;
  wr_entry_t   push_entry, pop_entry;

  // A simultaneous read is ignored, so the read branch only runs without a write.
  always_comb begin
    v_d  = v_q;
    t_d  = t_q;
    w_d  = w_q;
    push = 1'b0;
    if (cpu_wr_en) begin
      case (cpu_addr)
        REG_PPUADDR: begin
          if (!w_q) begin
            t_d = {cpu_data_in[5:0], t_q[7:0]};
            w_d = 1'b1;
          end else begin
            t_d = {t_q[13:8], cpu_data_in};
            v_d = t_d;
            w_d = 1'b0;
          end
        end
        REG_PPUDATA: begin
          push = 1'b1;
          v_d  = vram_next(v_q, inc32);
        end
        REG_PPUCTRL: ;
        default: ;
      endcase
    end else if (cpu_rd_en && (cpu_addr == REG_PPUSTATUS)) begin
      w_d = 1'b0;
    end
  end

  assign push_entry = '{addr: v_q, data: cpu_data_in};
  assign pop        = ~q_empty & mem_write_allow;
  assign overflow_d = overflow_q | (push & q_full & ~pop);

  ppu_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (pop_entry),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q          <= '0;
      t_q          <= '0;
      w_q          <= 1'b0;
      overflow_q   <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      v_q        <= v_d;
      t_q        <= t_d;
      w_q        <= w_d;
      overflow_q <= overflow_d;
      write_en_q <= pop;
      if (pop) begin
        write_addr_q <= {2'b00, pop_entry.addr};
        write_data_q <= pop_entry.data;
      end
    end
  end

  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign fifo_full  = q_full;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ppu_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_ppu_mem_ctrl : vector table + scoreboard bench for ppu_mem_ctrl
// Rev 1.0
// ----------------------------------------------------------------
module tb_ppu_mem_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_wr_en, cpu_rd_en, inc32, mem_write_allow;
  logic [15:0] write_addr;
  logic [7:0]  write_data;
  logic        write_en, fifo_full, overflow;

  ppu_mem_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_addr       (cpu_addr),
    .cpu_data_in    (cpu_data_in),
    .cpu_wr_en      (cpu_wr_en),
    .cpu_rd_en      (cpu_rd_en),
    .inc32          (inc32),
    .mem_write_allow(mem_write_allow),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .write_en       (write_en),
    .fifo_full      (fifo_full),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       wr;
    logic       rd;
    logic       inc32;
    logic       allow;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference state for the bench's own model of the block
  logic [13:0] vm, tm;
  logic        wm, ovf_m;
  int          occ;
  logic [15:0] last_addr;
  logic [7:0]  last_data;

  function automatic vec_t mk(input logic [2:0] a, input logic [7:0] d, input logic wr,
                              input logic rd, input logic i32, input logic al,
                              input logic ef, input logic eo);
    vec_t r;
    r.addr = a; r.data = d; r.wr = wr; r.rd = rd; r.inc32 = i32; r.allow = al;
    r.exp_full = ef; r.exp_ovf = eo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    vm = '0; tm = '0; wm = 1'b0; ovf_m = 1'b0; occ = 0;
    last_addr = '0; last_data = '0;
    sb.delete();
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input vec_t v, input bit chk_tab);
    logic        pop_m, acc;
    logic [21:0] e;
    cpu_addr = v.addr; cpu_data_in = v.data; cpu_wr_en = v.wr; cpu_rd_en = v.rd;
    inc32 = v.inc32; mem_write_allow = v.allow;
    @(posedge clk);
    pop_m = (occ > 0) && v.allow;
    acc   = 1'b0;
    if (v.wr) begin
      if (v.addr == 3'd6) begin
        if (!wm) begin tm[13:8] = v.data[5:0]; wm = 1'b1; end
        else begin tm[7:0] = v.data; vm = tm; wm = 1'b0; end
      end else if (v.addr == 3'd7) begin
        if (occ < DEPTH || pop_m) begin sb.push_back({vm, v.data}); acc = 1'b1; end
        else ovf_m = 1'b1;
        vm = (vm + (v.inc32 ? 14'd32 : 14'd1)) & 14'h3FFF;
      end
    end else if (v.rd && v.addr == 3'd2) begin
      wm = 1'b0;
    end
    occ = occ + int'(acc) - int'(pop_m);
    #1;
    check("write_en", 32'(write_en), 32'(pop_m));
    if (write_en) begin
      if (sb.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        last_addr = {2'b00, e[21:8]};
        last_data = e[7:0];
      end
    end
    check("write_addr", 32'(write_addr), 32'(last_addr));
    check("write_data", 32'(write_data), 32'(last_data));
    check("fifo_full", 32'(fifo_full), 32'(occ == DEPTH));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (chk_tab) begin
      check("tab_fifo_full", 32'(fifo_full), 32'(v.exp_full));
      check("tab_overflow", 32'(overflow), 32'(v.exp_ovf));
    end
  endtask

  task automatic idle(input logic al, input int n);
    for (int k = 0; k < n; k++) step(mk(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, al, 1'b0, 1'b0), 1'b0);
  endtask

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_wr_en = 0; cpu_rd_en = 0;
    inc32 = 0; mem_write_allow = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", 32'(write_data), 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Address latch, increments and wrap
    vecs.push_back(mk(6, 8'h23, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'h05, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'hAB, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'hCD, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'h3F, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'hE1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'h11, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(7, 8'h22, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    // Status read resets the toggle
    vecs.push_back(mk(6, 8'h3F, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'h21, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'h33, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'h00, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'h44, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    // Write wins over read; ignored registers
    vecs.push_back(mk(6, 8'h01, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2, 8'h00, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(6, 8'h80, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'h55, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'hFF, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(3, 8'hAA, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(5, 8'hBB, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(7, 8'h66, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    // Full queue: push on a pop edge is accepted
    vecs.push_back(mk(6, 8'h20, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 8'h00, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'hA0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'hA1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'hA2, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'hA3, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(7, 8'hA4, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
    // Overflow: fifth write dropped, address still advances
    vecs.push_back(mk(6, 8'h10, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(6, 8'h00, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h02, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h03, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 8'h04, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(7, 8'h05, 1, 0, 0, 0, 1, 1));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(7, 8'h06, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1));

    foreach (vecs[i]) step(vecs[i], 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset during the first of two drain writes
    step(mk(7, 8'h70, 1, 0, 0, 0, 0, 0), 1'b0);
    step(mk(7, 8'h71, 1, 0, 0, 0, 0, 0), 1'b0);
    idle(1'b1, 1);
    #2 rst = 1'b0;
    #1;
    check("async_write_en", 32'(write_en), 32'd0);
    check("async_write_addr", 32'(write_addr), 32'd0);
    check("async_write_data", 32'(write_data), 32'd0);
    check("async_fifo_full", 32'(fifo_full), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle(1'b1, 4);
    step(mk(7, 8'h77, 1, 0, 0, 1, 0, 0), 1'b0);
    idle(1'b1, 2);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
